// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-access-per-cycle block RAM.
// Port A (CPU) and port B (DMA/video) share the RAM with a bounded-burst fairness rule.
module bram_arbiter #(
  parameter int ADDR_W_p = 8,
  parameter int DATA_W_p = 16,
  parameter int BURST_p  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                a_req_i,
  input  logic                a_we_i,
  input  logic [ADDR_W_p-1:0] a_addr_i,
  input  logic [DATA_W_p-1:0] a_data_i,
  output logic                a_gnt_o,
  output logic                a_rvalid_o,

  input  logic                b_req_i,
  input  logic                b_we_i,
  input  logic [ADDR_W_p-1:0] b_addr_i,
  input  logic [DATA_W_p-1:0] b_data_i,
  output logic                b_gnt_o,
  output logic                b_rvalid_o,

  output logic [DATA_W_p-1:0] rdata_o,

  output logic                mem_write_o,
  output logic                mem_read_o,
  output logic [ADDR_W_p-1:0] mem_waddr_o,
  output logic [ADDR_W_p-1:0] mem_raddr_o,
  output logic [DATA_W_p-1:0] mem_data_o,
  input  logic [DATA_W_p-1:0] mem_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  localparam logic [7:0] BurstLim = 8'(BURST_p);

  owner_e     owner_q, owner_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       last_q, last_d;
  logic       rv_a_q, rv_b_q;
  logic       gnt_a, gnt_b;
  logic       under_burst;

  assign under_burst = (burst_cnt_q < BurstLim);

  // Grant decision; reset masks every grant so nothing reaches the RAM.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst_i) begin
      case (owner_q)
        IDLE: begin
          if (a_req_i && b_req_i) begin
            gnt_a = last_q;
            gnt_b = !last_q;
          end else begin
            gnt_a = a_req_i;
            gnt_b = b_req_i;
          end
        end
        OWN_A: begin
          if (a_req_i && (under_burst || !b_req_i)) gnt_a = 1'b1;
          else if (b_req_i)                         gnt_b = 1'b1;
          else if (a_req_i)                         gnt_a = 1'b1;
        end
        OWN_B: begin
          if (b_req_i && (under_burst || !a_req_i)) gnt_b = 1'b1;
          else if (a_req_i)                         gnt_a = 1'b1;
          else if (b_req_i)                         gnt_b = 1'b1;
        end
        default: begin
          gnt_a = 1'b0;
          gnt_b = 1'b0;
        end
      endcase
    end
  end

  // Ownership bookkeeping: staying with the owner extends the burst,
  // switching restarts it, and an idle cycle forgets the owner but keeps `last`.
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    last_d      = last_q;
    if (gnt_a) begin
      if (owner_q == OWN_A) begin
        burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
      end else begin
        owner_d     = OWN_A;
        burst_cnt_d = 8'd1;
        last_d      = 1'b0;
      end
    end else if (gnt_b) begin
      if (owner_q == OWN_B) begin
        burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
      end else begin
        owner_d     = OWN_B;
        burst_cnt_d = 8'd1;
        last_d      = 1'b1;
      end
    end else begin
      owner_d     = IDLE;
      burst_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q     <= IDLE;
      burst_cnt_q <= 8'd0;
      last_q      <= 1'b1;
      rv_a_q      <= 1'b0;
      rv_b_q      <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      rv_a_q      <= gnt_a & ~a_we_i;
      rv_b_q      <= gnt_b & ~b_we_i;
    end
  end

  // RAM strobes and buses follow the granted port; all zero when idle.
  always_comb begin
    mem_write_o = 1'b0;
    mem_read_o  = 1'b0;
    mem_waddr_o = '0;
    mem_raddr_o = '0;
    mem_data_o  = '0;
    if (gnt_a) begin
      mem_write_o = a_we_i;
      mem_read_o  = ~a_we_i;
      mem_waddr_o = a_addr_i;
      mem_raddr_o = a_addr_i;
      mem_data_o  = a_data_i;
    end else if (gnt_b) begin
      mem_write_o = b_we_i;
      mem_read_o  = ~b_we_i;
      mem_waddr_o = b_addr_i;
      mem_raddr_o = b_addr_i;
      mem_data_o  = b_data_i;
    end
  end

  assign a_gnt_o    = gnt_a;
  assign b_gnt_o    = gnt_b;
  assign a_rvalid_o = rv_a_q;
  assign b_rvalid_o = rv_b_q;
  assign rdata_o    = mem_data_i;

endmodule
